goodness_scheduler: RTL and testbench

GOODNESS_SCHEDULER -- requirements
Module: goodness_scheduler

---
 rtl/ff_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/goodness_scheduler.sv | 176 +++++++++++++++++
 tb/tb_goodness_scheduler.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ff_pkg.sv
// ff_pkg: shared types and constants for the forward-forward goodness scheduler.
//   state_t      - scheduler FSM states
//   Q_MAX/Q_MIN  - Q16.16 saturation limits applied to the pos-minus-neg delta
package ff_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        CAPTURE
    } state_t;

    localparam int unsigned       Q_WIDTH = 32;
    localparam logic [Q_WIDTH-1:0] Q_MAX  = 32'h7FFF_FFFF;
    localparam logic [Q_WIDTH-1:0] Q_MIN  = 32'h8000_0000;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req        in  N      request vector
//   last_grant in  IDX_W  most recently granted index; search starts one above it
//   grant      out N      one-hot winner (all zero when req is zero)
//   grant_idx  out IDX_W  binary index of the winner
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic        found;
    int unsigned cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = (32'(last_grant) + i) % N;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/goodness_scheduler.sv
// goodness_scheduler: shares one goodness engine among NUM_LAYERS layer requesters.
//   clk, rst_n                 clock, async active-low reset
//   req, req_neg               per-layer request (held until ack) and pass polarity (1 = negative)
//   ack                        one-cycle completion pulse to the granted layer
//   eng_start, eng_sel         engine start pulse and activation-buffer select
//   eng_done, eng_goodness     engine completion pulse and Q16.16 result
//   res_*                      per-pass result, res_valid is a one-cycle pulse
//   delta_*                    saturated pos-minus-neg goodness once both polarities are held
//   timeout_err, err_clr       sticky engine-timeout flag and its clear
// DATA_WIDTH is expected to be the 32-bit Q16.16 width of the package limits.
module goodness_scheduler
    import ff_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WAIT_LIMIT = 264
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_LAYERS-1:0]         req,
    input  logic [NUM_LAYERS-1:0]         req_neg,
    output logic [NUM_LAYERS-1:0]         ack,
    output logic                          eng_start,
    output logic [$clog2(NUM_LAYERS)-1:0] eng_sel,
    input  logic                          eng_done,
    input  logic [DATA_WIDTH-1:0]         eng_goodness,
    output logic                          res_valid,
    output logic [$clog2(NUM_LAYERS)-1:0] res_layer,
    output logic                          res_neg,
    output logic [DATA_WIDTH-1:0]         res_goodness,
    output logic                          delta_valid,
    output logic [$clog2(NUM_LAYERS)-1:0] delta_layer,
    output logic [DATA_WIDTH-1:0]         delta,
    output logic                          timeout_err,
    input  logic                          err_clr
);

    localparam int unsigned IDX_W = $clog2(NUM_LAYERS);
    localparam int unsigned CNT_W = $clog2(WAIT_LIMIT + 1);

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        last_grant, gnt_idx, arb_idx;
    logic [NUM_LAYERS-1:0]   gnt_oh, arb_oh;
    logic                    gnt_neg, timed_out, wait_hit;
    logic [CNT_W-1:0]        wait_cnt;
    logic [DATA_WIDTH-1:0]   cap_val;
    logic [NUM_LAYERS-1:0]   pos_have, neg_have;
    logic [DATA_WIDTH-1:0]   pos_val [NUM_LAYERS];
    logic [DATA_WIDTH-1:0]   neg_val [NUM_LAYERS];
    logic [DATA_WIDTH-1:0]   cur_pos, cur_neg, delta_sat;
    logic signed [DATA_WIDTH:0] diff;
    logic                    other_have;

    rr_arbiter #(.N(NUM_LAYERS), .IDX_W(IDX_W)) u_arb (
        .req        (req),
        .last_grant (last_grant),
        .grant      (arb_oh),
        .grant_idx  (arb_idx)
    );

    assign wait_hit = (wait_cnt == CNT_W'(WAIT_LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (|req) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (eng_done || wait_hit) state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A timeout also routes through CAPTURE so the ack lands while the FSM
    // still ignores req, preventing an immediate re-grant of the held request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= IDX_W'(NUM_LAYERS - 1);
            gnt_idx    <= '0;
            gnt_oh     <= '0;
            gnt_neg    <= 1'b0;
            timed_out  <= 1'b0;
            wait_cnt   <= '0;
            cap_val    <= '0;
            pos_have   <= '0;
            neg_have   <= '0;
            for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                pos_val[i] <= '0;
                neg_val[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: if (|req) begin
                    gnt_idx    <= arb_idx;
                    gnt_oh     <= arb_oh;
                    gnt_neg    <= req_neg[arb_idx];
                    last_grant <= arb_idx;
                end
                START: begin
                    wait_cnt  <= '0;
                    timed_out <= 1'b0;
                end
                WAIT: begin
                    if (eng_done)      cap_val   <= eng_goodness;
                    else if (wait_hit) timed_out <= 1'b1;
                    else               wait_cnt  <= wait_cnt + CNT_W'(1);
                end
                CAPTURE: if (!timed_out) begin
                    if (gnt_neg) neg_val[gnt_idx] <= cap_val;
                    else         pos_val[gnt_idx] <= cap_val;
                    if (other_have) begin
                        pos_have[gnt_idx] <= 1'b0;
                        neg_have[gnt_idx] <= 1'b0;
                    end else if (gnt_neg) begin
                        neg_have[gnt_idx] <= 1'b1;
                    end else begin
                        pos_have[gnt_idx] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A timeout in the same cycle as err_clr wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                      timeout_err <= 1'b0;
        else if (state == WAIT && !eng_done && wait_hit) timeout_err <= 1'b1;
        else if (err_clr)                                timeout_err <= 1'b0;
    end

    // Delta uses the freshly captured value in place of its stored polarity.
    always_comb begin
        other_have = gnt_neg ? pos_have[gnt_idx] : neg_have[gnt_idx];
        cur_pos    = gnt_neg ? pos_val[gnt_idx] : cap_val;
        cur_neg    = gnt_neg ? cap_val : neg_val[gnt_idx];
        diff       = $signed({cur_pos[DATA_WIDTH-1], cur_pos}) - $signed({cur_neg[DATA_WIDTH-1], cur_neg});
        if (diff[DATA_WIDTH] != diff[DATA_WIDTH-1])
            delta_sat = diff[DATA_WIDTH] ? DATA_WIDTH'(Q_MIN) : DATA_WIDTH'(Q_MAX);
        else
            delta_sat = diff[DATA_WIDTH-1:0];
    end

    always_comb begin
        ack          = '0;
        res_valid    = 1'b0;
        res_layer    = '0;
        res_neg      = 1'b0;
        res_goodness = '0;
        delta_valid  = 1'b0;
        delta_layer  = '0;
        delta        = '0;
        eng_start    = (state == START);
        eng_sel      = gnt_idx;
        if (state == CAPTURE) begin
            ack = gnt_oh;
            if (!timed_out) begin
                res_valid    = 1'b1;
                res_layer    = gnt_idx;
                res_neg      = gnt_neg;
                res_goodness = cap_val;
                if (other_have) begin
                    delta_valid = 1'b1;
                    delta_layer = gnt_idx;
                    delta       = delta_sat;
                end
            end
        end
    end

endmodule

// File: tb/tb_goodness_scheduler.sv
// tb_goodness_scheduler: directed and randomized checks of goodness_scheduler
// against a transaction-level model (round-robin pick, per-layer pos/neg store,
// clamped 64-bit subtraction, sticky error flag).
module tb_goodness_scheduler;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int WL = 264;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req = '0, req_neg = '0, ack;
    logic          eng_start, eng_done = 1'b0;
    logic [1:0]    eng_sel, res_layer, delta_layer;
    logic [DW-1:0] eng_goodness = '0, res_goodness, delta;
    logic          res_valid, res_neg, delta_valid, timeout_err, err_clr = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    int          last_g;
    bit          ph [N];
    bit          nh [N];
    logic [31:0] pv [N];
    logic [31:0] nv [N];
    bit          err;

    goodness_scheduler #(.NUM_LAYERS(N), .DATA_WIDTH(DW), .WAIT_LIMIT(WL)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_neg(req_neg), .ack(ack),
        .eng_start(eng_start), .eng_sel(eng_sel), .eng_done(eng_done),
        .eng_goodness(eng_goodness), .res_valid(res_valid), .res_layer(res_layer),
        .res_neg(res_neg), .res_goodness(res_goodness), .delta_valid(delta_valid),
        .delta_layer(delta_layer), .delta(delta), .timeout_err(timeout_err),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] rq, input int last);
        for (int i = 1; i <= N; i++) begin
            if (rq[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] p, input logic [31:0] n);
        longint dd;
        dd = longint'($signed(p)) - longint'($signed(n));
        if (dd > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (dd < -64'sd2147483648) return 32'h8000_0000;
        return dd[31:0];
    endfunction

    task automatic model_reset();
        last_g = N - 1;
        err    = 1'b0;
        for (int i = 0; i < N; i++) begin
            ph[i] = 1'b0; nh[i] = 1'b0; pv[i] = '0; nv[i] = '0;
        end
    endtask

    task automatic check_quiet(input string tag);
        chk(tag, {ack, eng_start, eng_sel, res_valid, res_layer, res_neg,
                  delta_valid, delta_layer, timeout_err}, 64'd0);
        chk({tag, "_data"}, {res_goodness, delta}, 64'd0);
    endtask

    // Leaves the bench at a sample point with the DUT idle.
    task automatic do_reset();
        req = '0; eng_done = 1'b0; err_clr = 1'b0;
        rst_n = 1'b0;
        #1;
        check_quiet("reset_async");
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        check_quiet("reset_release");
    endtask

    // One pass: d = cycles after the eng_start cycle at which eng_done is
    // driven, 0 = never (timeout). Entered and left at an idle sample point.
    task automatic pass(input logic [N-1:0] rq, input logic [N-1:0] rn, input int d,
                        input logic [31:0] g, input bit keep, input bit clr_hold);
        int          w, exp_k;
        bit          neg, exp_dv;
        logic [31:0] exp_delta;
        logic [N-1:0] one;
        req = rq; req_neg = rn;
        w = rr_pick(rq, last_g);
        one = '0; one[w] = 1'b1;
        @(posedge clk); #1;
        chk("start", {ack, eng_start, eng_sel}, {4'b0, 1'b1, 2'(w)});
        last_g = w;
        neg = rn[w];
        req_neg = N'($urandom);
        if (!keep && $urandom_range(0, 1) == 1) req[w] = 1'b0;
        eng_done = 1'b1; eng_goodness = $urandom;
        err_clr = clr_hold;
        exp_k = (d > 0) ? d + 1 : WL + 1;
        for (int k = 1; k <= exp_k; k++) begin
            @(posedge clk); #1;
            eng_done = 1'b0;
            if (k < exp_k) begin
                chk("wait", {ack, eng_start, res_valid, delta_valid, eng_sel},
                    {4'b0, 1'b0, 1'b0, 1'b0, 2'(w)});
            end else if (d == 0) begin
                err = 1'b1;
                chk("to_ack", {ack, eng_sel}, {one, 2'(w)});
                chk("to_res", {res_valid, delta_valid}, 64'd0);
                chk("to_err", timeout_err, 1'b1);
            end else begin
                exp_dv = 1'b0;
                exp_delta = '0;
                if (neg) begin nv[w] = g; nh[w] = 1'b1; end
                else     begin pv[w] = g; ph[w] = 1'b1; end
                if (ph[w] && nh[w]) begin
                    exp_dv = 1'b1;
                    exp_delta = sat_sub(pv[w], nv[w]);
                    ph[w] = 1'b0; nh[w] = 1'b0;
                end
                chk("ack", {ack, eng_sel}, {one, 2'(w)});
                chk("res", {res_valid, res_layer, res_neg}, {1'b1, 2'(w), neg});
                chk("res_goodness", res_goodness, g);
                chk("delta_valid", delta_valid, exp_dv);
                if (exp_dv) chk("delta", {delta_layer, delta}, {2'(w), exp_delta});
                chk("err_keep", timeout_err, err);
            end
            if (k == d) begin eng_done = 1'b1; eng_goodness = g; end
        end
        err_clr = 1'b0;
        eng_done = 1'b1;
        eng_goodness = $urandom;
        if (!keep) req[w] = 1'b0;
        @(posedge clk); #1;
        eng_done = 1'b0;
        chk("post", {ack, eng_start, res_valid, delta_valid}, 64'd0);
        chk("post_err", timeout_err, err);
    endtask

    initial begin
        logic [N-1:0] rq;
        model_reset();
        @(posedge clk); #1;
        do_reset();

        // all layers requesting continuously: rotation from layer 0
        for (int i = 0; i < 5; i++) pass(4'hF, N'($urandom), $urandom_range(1, 6), $urandom, 1'b1, 1'b0);
        req = '0;
        @(posedge clk); #1;
        chk("drop_before_grant", {eng_start, ack}, 64'd0);

        do_reset();
        pass(4'b0100, 4'b0000, 258, 32'h0003_0000, 1'b0, 1'b0);
        pass(4'b0010, 4'b0000, 5, 32'h0005_0000, 1'b0, 1'b0);
        pass(4'b0010, 4'b0010, 7, 32'h0002_0000, 1'b0, 1'b0);
        pass(4'b1000, 4'b0000, 3, 32'h7FFF_FFFF, 1'b0, 1'b0);
        pass(4'b1000, 4'b1000, 2, 32'h8000_0000, 1'b0, 1'b0);
        pass(4'b1000, 4'b0000, 1, 32'h8000_0000, 1'b0, 1'b0);
        pass(4'b1000, 4'b1000, WL, 32'h7FFF_FFFF, 1'b0, 1'b0);

        // timeout, then clear; then timeout coinciding with err_clr
        pass(4'b0001, 4'b0000, 0, '0, 1'b0, 1'b0);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0; err = 1'b0;
        chk("err_clr", timeout_err, 1'b0);
        pass(4'b0001, 4'b0001, 0, '0, 1'b0, 1'b1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0; err = 1'b0;
        chk("err_clr2", timeout_err, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rq = N'($urandom_range(1, 15));
            pass(rq, N'($urandom), $urandom_range(1, 40), $urandom, 1'b0, 1'b0);
        end

        // reset while waiting on the engine; a late eng_done must be ignored
        req = 4'b0001; req_neg = '0;
        @(posedge clk); #1;
        chk("rst_mid_start", eng_start, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        req = '0;
        rst_n = 1'b0;
        #1;
        check_quiet("rst_mid_async");
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        eng_done = 1'b1; eng_goodness = 32'h1234_5678;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            eng_done = 1'b0;
            check_quiet("rst_mid_after");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
